// File: rtl/sme_feeder.sv
// sme_feeder: host-side driver for the string-matching engine's character
// stream. The host appends characters into a string buffer (1..STR_MAX) and a
// pattern buffer (1..PAT_MAX). On start, the string and then the pattern are
// streamed back-to-back on chardata/isstring/ispattern. The block then waits
// for the engine's valid strobe and latches match/match_index as the result.
//
// Optional feature: define SME_FEEDER_TIMEOUT_EN to add a WAIT watchdog. If
// valid has not arrived after TO_CYCLES cycles, the block completes with
// timeout=1. Without the macro, timeout is tied low and WAIT has no limit.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   wr_en, wr_sel, wr_data      host append (wr_sel 0 = string, 1 = pattern)
//   start, keep_str             run request; keep_str skips the string phase
//   busy, done, err             status (done and err are one-cycle pulses)
//   res_match, res_index        latched engine result
//   timeout                     result came from the watchdog
//   chardata, isstring,         character stream to the engine
//   ispattern
//   valid, match, match_index   engine result inputs
module sme_feeder #(
  parameter int STR_MAX   = 32,
  parameter int PAT_MAX   = 8,
  parameter int TO_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       keep_str,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       timeout,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index
);
  localparam int SW  = $clog2(STR_MAX + 1);
  localparam int PW  = $clog2(PAT_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int IW  = (SW > PW) ? SW : PW;

  typedef enum logic [2:0] {IDLE, SEND_S, SEND_P, WAIT, DONE} state_t;
  typedef struct packed {
    logic       match;
    logic [4:0] index;
  } res_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [7:0]    str_mem [STR_MAX];
  logic [7:0]    pat_mem [PAT_MAX];
  logic [SW-1:0] slen, s_cnt, tx_slen;
  logic [PW-1:0] plen, tx_plen;
  logic          str_sent, str_clr;
  res_t          res_q, res_n;
  logic [7:0]    chardata_n;
  logic          isstring_n, ispattern_n, busy_n, done_n;
  logic          start_err, load_tx, finish;
  logic          wr_acc, wr_s, wr_p, wr_ovf;
  logic [IW-1:0] last_s, last_p;

  // A string write after a completed run restarts the string at index 0.
  // The old contents remain valid until that write so they can be resent.
  assign s_cnt  = str_clr ? '0 : slen;
  assign wr_acc = wr_en && !busy && !reset;
  assign wr_s   = wr_acc && !wr_sel && (s_cnt != SW'(STR_MAX));
  assign wr_p   = wr_acc &&  wr_sel && (plen  != PW'(PAT_MAX));
  assign wr_ovf = wr_acc && (wr_sel ? (plen == PW'(PAT_MAX)) : (s_cnt == SW'(STR_MAX)));

  // The stream uses lengths latched at start. A write in the same cycle as
  // start lands in the buffer but does not extend the run in progress.
  assign last_s = IW'(tx_slen) - IW'(1);
  assign last_p = IW'(tx_plen) - IW'(1);

`ifdef SME_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          timeout_q, timeout_n;
`endif

  // Outputs are registered. This block computes what the next cycle drives.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    chardata_n  = '0;
    isstring_n  = 1'b0;
    ispattern_n = 1'b0;
    busy_n      = busy;
    done_n      = 1'b0;
    res_n       = res_q;
    start_err   = 1'b0;
    load_tx     = 1'b0;
    finish      = 1'b0;
`ifdef SME_FEEDER_TIMEOUT_EN
    timeout_n   = timeout_q;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          if (plen == '0 || (!keep_str && slen == '0) || (keep_str && !str_sent)) begin
            start_err = 1'b1;
          end else begin
            load_tx = 1'b1;
            busy_n  = 1'b1;
            idx_n   = '0;
            if (keep_str) begin
              state_n     = SEND_P;
              chardata_n  = pat_mem[0];
              ispattern_n = 1'b1;
            end else begin
              state_n    = SEND_S;
              chardata_n = str_mem[0];
              isstring_n = 1'b1;
            end
          end
        end
      end
      SEND_S: begin
        // The first pattern character follows the last string character
        // directly, with no gap cycle.
        if (idx == last_s) begin
          state_n     = SEND_P;
          idx_n       = '0;
          chardata_n  = pat_mem[0];
          ispattern_n = 1'b1;
        end else begin
          idx_n      = idx + IW'(1);
          chardata_n = str_mem[idx_n[SAW-1:0]];
          isstring_n = 1'b1;
        end
      end
      SEND_P: begin
        if (idx == last_p) begin
          state_n = WAIT;
        end else begin
          idx_n       = idx + IW'(1);
          chardata_n  = pat_mem[idx_n[PAW-1:0]];
          ispattern_n = 1'b1;
        end
      end
      WAIT: begin
        if (valid) begin
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          finish  = 1'b1;
          res_n   = '{match: match, index: match_index};
`ifdef SME_FEEDER_TIMEOUT_EN
          timeout_n = 1'b0;
        end else if (to_cnt == TW'(TO_CYCLES - 1)) begin
          // This is the last WAIT cycle. A valid in this cycle takes
          // priority through the branch above.
          state_n   = DONE;
          done_n    = 1'b1;
          busy_n    = 1'b0;
          finish    = 1'b1;
          res_n     = '0;
          timeout_n = 1'b1;
`endif
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      chardata  <= '0;
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      res_q     <= '0;
      slen      <= '0;
      plen      <= '0;
      tx_slen   <= '0;
      tx_plen   <= '0;
      str_sent  <= 1'b0;
      str_clr   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      chardata  <= chardata_n;
      isstring  <= isstring_n;
      ispattern <= ispattern_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= start_err | wr_ovf;
      res_q     <= res_n;
      if (load_tx) begin
        tx_slen <= slen;
        tx_plen <= plen;
        if (!keep_str) str_sent <= 1'b1;
      end
      if (wr_s) begin
        slen    <= s_cnt + SW'(1);
        str_clr <= 1'b0;
      end
      // finish happens only while busy, so it never coincides with a write.
      if (finish) begin
        plen    <= '0;
        str_clr <= 1'b1;
      end else if (wr_p) begin
        plen <= plen + PW'(1);
      end
    end
  end

  // The buffers are not reset. The lengths alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_s) str_mem[s_cnt[SAW-1:0]] <= wr_data;
    if (wr_p) pat_mem[plen[PAW-1:0]]  <= wr_data;
  end

  assign res_match = res_q.match;
  assign res_index = res_q.index;

`ifdef SME_FEEDER_TIMEOUT_EN
  // The counter holds 0 outside WAIT, so it starts from 0 on every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_n;
      if (state == WAIT) to_cnt <= to_cnt + TW'(1);
      else               to_cnt <= '0;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/sme_feeder.md
# sme_feeder

Host-side driver for the string-matching engine's character-stream interface. It buffers a target string (1–32 chars) and a pattern (1–8 chars) written by a host, then serializes them onto `chardata`/`isstring`/`ispattern` in the exact order and contiguity the engine requires. It waits for the engine's `valid`, captures `match` and `match_index`, and reports the result back to the host. It sits between the host/testbench logic and the matcher, as the transmitting end of that interface.

## Interface
- `STR_MAX`, 32, string buffer depth; lengths 1..32.
- `PAT_MAX`, 8, pattern buffer depth; lengths 1..8.
- `TO_CYCLES`, 1023, watchdog limit in cycles (used only with `SME_FEEDER_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  host write strobe, one character per cycle.
- `wr_sel`  in  1  0 = string buffer, 1 = pattern buffer.
- `wr_data`  in  8  character to append.
- `start`  in  1  one-cycle request to run a transaction.
- `keep_str`  in  1  sampled with `start`; 1 = skip the string phase and reuse the string already in the engine.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; result fields valid this cycle and held afterwards.
- `err`  out  1  one-cycle pulse when a `start` is rejected or a write overflows.
- `res_match`  out  1  captured `match`.
- `res_index`  out  5  captured `match_index`.
- `timeout`  out  1  result came from the watchdog, not from the engine.
- `chardata`  out  8  character to the engine.
- `isstring`  out  1  `chardata` is a string character.
- `ispattern`  out  1  `chardata` is a pattern character.
- `valid`  in  1  engine result strobe.
- `match`  in  1  engine match flag.
- `match_index`  in  5  engine match position.

## Operation
- **States:** `IDLE`, `SEND_S`, `SEND_P`, `WAIT`, `DONE`.
- **Buffer writes**
  - Accepted only while `busy` is 0.
  - Each write appends at `slen` or `plen` and increments that count.
  - A write when the count equals `STR_MAX` or `PAT_MAX` is dropped and pulses `err`.
  - The first string write after a `done` clears `slen` to 0 before appending, so the new string starts at index 0.
  - `plen` clears to 0 on `done`.
- **Start acceptance (in `IDLE`)**
  - Rejected with `err` and no state change if `plen`=0.
  - Rejected with `err` and no state change if `slen`=0 and `keep_str`=0.
  - Rejected with `err` and no state change if `keep_str`=1 and no string has ever been sent since reset.
  - Otherwise goes to `SEND_S`, or to `SEND_P` if `keep_str`=1.
  - `start` outside `IDLE` is ignored, with no `err`.
- **`SEND_S`**: drives `isstring`=1 with `str[k]` for k = 0..`slen`-1, one character per cycle, no gaps; then `SEND_P`.
- **`SEND_P`**: drives `ispattern`=1 with `pat[k]` for k = 0..`plen`-1, contiguous with the last string cycle; then `WAIT`.
- **`WAIT`**: `isstring`=`ispattern`=0 and `chardata`=0. On `valid`=1, captures `match` and `match_index` into `res_match`/`res_index`, clears `timeout`, and goes to `DONE`.
- **`DONE`**: pulses `done` for one cycle, drops `busy`, then returns to `IDLE`.
- `valid` outside `WAIT` is ignored.
- `isstring` and `ispattern` are never high in the same cycle.

## Timing
- All outputs are registered.
- **Reset values:** `chardata`=0, `isstring`=0, `ispattern`=0, `busy`=0, `done`=0, `err`=0, `res_match`=0, `res_index`=0, `timeout`=0. Also `slen`=`plen`=0, state `IDLE`, string-sent flag 0.
- **Start:** `start` is sampled at edge T. `busy` and the first `isstring`/`ispattern` cycle appear after edge T (first drive cycle T+1).
- **Stream length:** `isstring` high for exactly `slen` cycles, immediately followed by `ispattern` high for exactly `plen` cycles.
- **Result:** `valid` sampled at edge V; `done` is high in cycle V+1 with the result fields updated.
- **Back-to-back:** the next `start` is accepted no earlier than the cycle after `done`.
- **`err`:** asserted the cycle after the offending `start` or write.
- **Simultaneous write and `start` in `IDLE`:** the write is applied and `start` evaluates the pre-write counts.
- **Reset mid-transaction:** the stream aborts immediately, all outputs return to reset values the next cycle, and buffers are logically emptied.

## Configuration
- **With `SME_FEEDER_TIMEOUT_EN` defined**
  - A counter clears on entry to `WAIT` and increments each cycle in `WAIT`.
  - When it reaches `TO_CYCLES` without `valid`, the block goes to `DONE` with `timeout`=1, `res_match`=0, `res_index`=0.
  - If `valid` arrives in the same cycle the limit is reached, `valid` wins.
- **Without it:** no counter exists, `timeout` is tied to 0, and `WAIT` lasts indefinitely.

## Test plan
- Write string "ab cd" (5 chars) and pattern "cd", then `start` → `isstring` high 5 consecutive cycles with 61,62,20,63,64; then `ispattern` 2 cycles with 63,64. Engine model returns `valid` with `match`=1, `match_index`=3 → next cycle `done`=1, `res_match`=1, `res_index`=3.
- After the prior run, write pattern "x" and `start` with `keep_str`=1 → no `isstring` cycles; `ispattern`=1 with 78 for exactly 1 cycle starting the cycle after `start`.
- Write 33 string characters → the 33rd is dropped, `err` pulses once, and a following run streams exactly 32 characters.
- `start` with `plen`=0 → `err`=1 one cycle, `busy` stays 0, and no stream appears.
- Assert `reset` on the 3rd `isstring` cycle → next cycle all outputs are 0 and state is `IDLE`; `start` then gives `err` because the buffers are empty.
- With `SME_FEEDER_TIMEOUT_EN` and `TO_CYCLES`=8, the engine never asserts `valid` → `done` with `timeout`=1 and `res_match`=0 after 8 `WAIT` cycles. Without the macro, `busy` stays high for 100+ cycles.
